// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared constants and types for the systolic operand feeder
package systolic_pkg;

  localparam int N            = 3;
  localparam int DATA_W       = 32;
  localparam int DRAIN_CYCLES = 4;
  localparam int IDX_W        = $clog2(N);
  localparam int CNT_W        = 8;
  localparam int BEATS        = 2 * N - 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef data_t [N-1:0]     vec_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - operand write port, run control and array-facing wavefront bus
interface systolic_feeder_if;
  import systolic_pkg::*;

  logic                  wr_en;
  logic                  wr_sel;
  logic [IDX_W-1:0]      wr_row;
  logic [IDX_W-1:0]      wr_col;
  data_t                 wr_data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  arr_clr;
  logic [N*DATA_W-1:0]   a_out;
  logic [N*DATA_W-1:0]   b_out;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, arr_clr, a_out, b_out
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, arr_clr, a_out, b_out
  );

endinterface

// File: rtl/systolic_feeder_lane.sv
// rtl/systolic_feeder_lane.sv - one skewed lane: picks vec[t - LANE] inside the window, else 0
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [CNT_W-1:0] t_i,
  input  logic             valid_i,
  input  vec_t             vec_i,
  output data_t            elem_o
);

  logic [CNT_W-1:0] off;

  always_comb begin
    off    = t_i - CNT_W'(LANE);
    elem_o = '0;
    if (valid_i && (t_i >= CNT_W'(LANE)) && (off < CNT_W'(N))) begin
      elem_o = vec_i[off[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand store + clear/stream/drain sequencer for the NxN array (SYSTOLIC_FEEDER_TRANSPOSE_EN)
module systolic_feeder
  import systolic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
);

  feeder_state_t       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  vec_t                a_mem_q [N];
  vec_t                b_mem_q [N];
  vec_t                b_col   [N];
  data_t               a_lane  [N];
  data_t               b_lane  [N];
  logic                streaming;
  logic                busy_d, done_d, clr_d;
  logic                busy_q, done_q, clr_q;
  logic [N*DATA_W-1:0] a_out_d, b_out_d, a_out_q, b_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: if (cnt_q == CNT_W'(BEATS - 1)) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      DRAIN: if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
        state_d = DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand writes only land while idle so a running wavefront never changes under the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        a_mem_q[r] <= '0;
        b_mem_q[r] <= '0;
      end
    end else if (bus.wr_en && (state_q == IDLE)) begin
      if (!bus.wr_sel) begin
        a_mem_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end else begin
`ifdef SYSTOLIC_FEEDER_TRANSPOSE_EN
        b_mem_q[bus.wr_col][bus.wr_row] <= bus.wr_data;
`else
        b_mem_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
`endif
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < N; r++) begin
        b_col[j][r] = b_mem_q[r][j];
      end
    end
  end

  assign streaming = (state_q == STREAM);

  for (genvar i = 0; i < N; i++) begin : g_lane
    feeder_lane #(.LANE(i)) u_a_lane (
      .t_i    (cnt_q),
      .valid_i(streaming),
      .vec_i  (a_mem_q[i]),
      .elem_o (a_lane[i])
    );
    feeder_lane #(.LANE(i)) u_b_lane (
      .t_i    (cnt_q),
      .valid_i(streaming),
      .vec_i  (b_col[i]),
      .elem_o (b_lane[i])
    );
  end

  always_comb begin
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);
    clr_d   = (state_q == CLEAR);
    a_out_d = '0;
    b_out_d = '0;
    for (int i = 0; i < N; i++) begin
      a_out_d[i*DATA_W +: DATA_W] = a_lane[i];
      b_out_d[i*DATA_W +: DATA_W] = b_lane[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      a_out_q <= '0;
      b_out_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.arr_clr = clr_q;
  assign bus.a_out   = a_out_q;
  assign bus.b_out   = b_out_q;

endmodule
